// File: rtl/dna_pack.sv
// Packs 2-bit nucleotide symbols MSB-first into 32-bit words, 16 symbols per word.
// Partial words are closed by sym_last, padded with PAD_SYM and tagged with their symbol count.
module dna_pack #(
  parameter logic [1:0] PAD_SYM = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [1:0]  sym_i,
  input  logic        sym_last,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_o,
  output logic [4:0]  word_cnt,
  output logic        word_last
);

  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        acc_last_q, acc_last_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;
  logic [4:0]  word_cnt_q, word_cnt_d;
  logic        word_last_q, word_last_d;

  logic        sym_fire;
  logic        out_free;
  logic        complete;
  logic [4:0]  cnt_inc;
  logic [31:0] ins_word;
  logic [31:0] done_word;

  assign sym_ready  = !pend_q;
  assign sym_fire   = sym_valid & sym_ready;
  assign out_free   = !word_valid_q | word_ready;
  assign cnt_inc    = cnt_q + 5'd1;
  assign complete   = sym_fire & ((cnt_inc == 5'd16) | sym_last);

  assign word_valid = word_valid_q;
  assign word_o     = word_q;
  assign word_cnt   = word_cnt_q;
  assign word_last  = word_last_q;

  // ins_word: accumulator with the incoming symbol in slot cnt.
  // done_word: same, with every slot at or beyond the new count replaced by padding.
  always_comb begin
    ins_word  = acc_q;
    done_word = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) == cnt_q) ins_word[31-2*i -: 2] = sym_i;
      done_word[31-2*i -: 2] = (5'(i) < cnt_inc) ? ins_word[31-2*i -: 2] : PAD_SYM;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    acc_last_d   = acc_last_q;
    word_valid_d = word_valid_q & ~word_ready;
    word_d       = word_q;
    word_cnt_d   = word_cnt_q;
    word_last_d  = word_last_q;

    if (pend_q) begin
      if (out_free) begin
        word_valid_d = 1'b1;
        word_d       = acc_q;
        word_cnt_d   = cnt_q;
        word_last_d  = acc_last_q;
        acc_d        = '0;
        cnt_d        = '0;
        pend_d       = 1'b0;
        acc_last_d   = 1'b0;
      end
    end else if (complete) begin
      if (out_free) begin
        // Direct load keeps acceptance at one symbol per cycle.
        word_valid_d = 1'b1;
        word_d       = done_word;
        word_cnt_d   = cnt_inc;
        word_last_d  = sym_last;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d      = done_word;
        cnt_d      = cnt_inc;
        pend_d     = 1'b1;
        acc_last_d = sym_last;
      end
    end else if (sym_fire) begin
      acc_d = ins_word;
      cnt_d = cnt_inc;
    end
  end

  // NOTE: the output registers are reset too, so word_o/word_cnt/word_last read zero immediately on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      acc_last_q   <= 1'b0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      word_cnt_q   <= '0;
      word_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state.
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      acc_last_q   <= acc_last_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      word_cnt_q   <= word_cnt_d;
      word_last_q  <= word_last_d;
    end
  end

endmodule

// File: doc/dna_pack.md
Name: dna_pack

Overview:
- Packs a stream of 2-bit nucleotide symbols into 32-bit words. It is the write-side counterpart of the word-to-symbol unpacker in the DNA datapath.
- Used to store aligned or traceback sequences and reference and read fragments back into 32-bit memory.
- 16 symbols per word, MSB-first: the first symbol lands in bits [31:30].
- Valid/ready handshake on both sides. Partial words are emitted on sym_last, padded, and tagged with the symbol count.

Parameters:
- PAD_SYM, 2'b00: 2-bit value written into every unused slot of a partial word.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. This is the single clock domain; reset asserts asynchronously and is released synchronously by the integrator.
- sym_valid  in  1  symbol present on sym_i.
- sym_ready  out  1  block accepts a symbol this cycle.
- sym_i  in  2  nucleotide symbol.
- sym_last  in  1  qualifies sym_i as the final symbol of the sequence.
- word_valid  out  1  packed word present on word_o.
- word_ready  in  1  sink consumes word_o this cycle.
- word_o  out  32  packed word.
- word_cnt  out  5  number of valid symbols in word_o, range 1..16.
- word_last  out  1  word_o ends the sequence.

Behaviour:
- Definitions:
  - Accept: sym_fire = sym_valid & sym_ready.
  - Output slot free: out_free = !word_valid | word_ready.
- Internal state:
  - acc[31:0]: accumulator.
  - cnt[4:0]: symbols held, 0..16.
  - pend: acc holds a complete or terminated word awaiting the output slot.
  - acc_last: pending word is the final one.
  - Output registers: word_o, word_cnt, word_last, word_valid.
- Packing: the symbol accepted with cnt=k (0..15) is written to acc[31-2k -: 2]. cnt increments on each sym_fire.
- Word completion: the word completes on the sym_fire where cnt becomes 16, or on any sym_fire with sym_last=1.
  - Completed word value: acc with the new symbol inserted and every slot at or beyond the new cnt filled with PAD_SYM.
- Completion with out_free=1 in the same cycle:
  - The word loads directly into the output registers at that edge, so word_valid=1 on the next cycle.
  - Latency is 1 cycle from the completing accept to word_valid.
  - cnt returns to 0 and pend stays 0, so accept continues at full rate of 1 symbol per cycle.
- Completion with out_free=0:
  - The word stays in acc; pend=1 and acc_last=sym_last.
  - sym_ready=0 while pend=1.
  - On the first edge with pend=1 and out_free=1, acc moves to the output registers, and pend and cnt clear.
  - sym_ready returns high the cycle after that edge.
- sym_ready = !pend. It is combinational from state only and never depends on sym_valid.
- word_valid:
  - Set when a word loads.
  - Cleared on word_ready unless a new word loads on the same edge.
  - word_o, word_cnt and word_last are held stable while word_valid=1 and word_ready=0.
- Output ordering: at most one word in acc plus one in the output registers. Words leave strictly in completion order.
- sym_last on a symbol that also fills slot 16: word_cnt=16, word_last=1, no extra word emitted.
- sym_last is ignored when sym_fire=0. There is no empty-word emission.
- cnt never exceeds 16; acceptance is impossible when pend=1.
- Reset (rst_n=0, any time, including mid-word):
  - acc=0, cnt=0, pend=0, acc_last=0.
  - word_valid=0, word_o=32'h0, word_cnt=0, word_last=0.
  - sym_ready=1 once rst_n is released.
  - A partially packed word is discarded.

Test Plan:
- Full-rate word: 16 symbols 0,1,2,3 repeating, one per cycle, word_ready=1.
  - Required: word_o=32'h1B1B1B1B, word_cnt=16, word_last=0, word_valid high exactly 1 cycle, 1 cycle after the 16th accept.
  - Required: sym_ready never drops.
- Partial word: symbols 3,2,1 with sym_last on the third, PAD_SYM=0.
  - Required: word_o=32'hE4000000, word_cnt=3, word_last=1.
  - Repeat with PAD_SYM=2'b11: required word_o=32'hE7FFFFFF.
- Backpressure: word_ready=0, stream 32 symbols of value 2 with sym_valid held.
  - Required: word1=32'hAAAAAAAA held stable; sym_ready=0 after the 32nd accept.
  - Raise word_ready for 1 cycle: word2=32'hAAAAAAAA appears the next cycle; sym_ready=1 the cycle after the move.
- Last on a full word: 16 symbols with sym_last on the 16th.
  - Required: exactly one word, word_cnt=16, word_last=1.
  - Required: the next symbol starts a fresh word at bits [31:30].
- Reset mid-word: accept 5 symbols, pulse rst_n low asynchronously between clock edges.
  - Required: word_valid, word_o, word_cnt and word_last are 0 immediately.
  - Then 16 symbols of value 1: required word_o=32'h55555555, word_cnt=16.
- Simultaneous consume and complete: word_valid=1 and word_ready=1 on the same edge as the 16th accept of the next word.
  - Required: the new word is presented the next cycle with no bubble, and no word is lost or duplicated (scoreboard check).
